// File: rtl/key_event_scheduler.sv
// Key event scheduler: turns debounced active-low key levels into press and
// auto-repeat events, one per key FSM, funnelled through a round-robin
// arbiter into a single registered valid/ready output slot.
//
// Output handshake: ev_valid/ev_key/ev_type are registered. An event is
// consumed on a rising edge where ev_valid and ev_ready are both high. While
// ev_valid=1 and ev_ready=0 the slot holds stable. The slot is free when it
// is empty or being consumed on this edge, and only then may a new grant load.
//
// dbg_state exposes each key FSM state as two bits (key i at [2i+1:2i]):
// 0 = IDLE, 1 = HOLD, 2 = RPT.
// N_KEYS must be at least 2.
module key_event_scheduler #(
   parameter int N_KEYS        = 4,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_KEYS-1:0]         key_in,
   input  logic                      ev_ready,
   output logic                      ev_valid,
   output logic [$clog2(N_KEYS)-1:0] ev_key,
   output logic                      ev_type,
   output logic [N_KEYS-1:0]         key_held,
   output logic [2*N_KEYS-1:0]       dbg_state
);

   localparam int KW   = $clog2(N_KEYS);
   localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);
   localparam logic [KW:0]   NK        = (KW+1)'(N_KEYS);
   localparam logic [KW-1:0] LAST_KEY  = KW'(N_KEYS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_RPT  = 2'd2
   } state_t;

   // Per-key state
   state_t            r_state [N_KEYS];
   logic [CW-1:0]     r_cnt   [N_KEYS];
   logic [N_KEYS-1:0] r_key_prev;
   logic [N_KEYS-1:0] r_pend_press;
   logic [N_KEYS-1:0] r_pend_rpt;

   // Output slot and arbiter pointer
   logic              r_ev_valid;
   logic [KW-1:0]     r_ev_key;
   logic              r_ev_type;
   logic [KW-1:0]     r_rr_ptr;

   // Combinational helpers
   logic [N_KEYS-1:0] w_press_edge;
   logic [N_KEYS-1:0] w_set_press;
   logic [N_KEYS-1:0] w_set_rpt;
   logic [N_KEYS-1:0] w_release;
   logic [N_KEYS-1:0] w_pend_any;
   logic [N_KEYS-1:0] w_clr_press;
   logic [N_KEYS-1:0] w_clr_rpt;
   logic              w_slot_free;
   logic              w_gnt_found;
   logic [KW-1:0]     w_gnt_idx;
   logic              w_grant;

   // (base + off) mod N_KEYS for operands already below N_KEYS
   function automatic logic [KW-1:0] f_wrap(input logic [KW-1:0] base,
                                            input logic [KW-1:0] off);
      logic [KW:0] s;
      s = {1'b0, base} + {1'b0, off};
      if (s >= NK) s = s - NK;
      return s[KW-1:0];
   endfunction

   assign w_press_edge = r_key_prev & ~key_in;
   assign w_pend_any   = r_pend_press | r_pend_rpt;
   assign w_slot_free  = ~r_ev_valid | ev_ready;
   assign w_grant      = w_slot_free & w_gnt_found;

   // Per-key flag requests derived from the current FSM state and counter
   always_comb begin
      w_set_press = '0;
      w_set_rpt   = '0;
      w_release   = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         case (r_state[i])
            S_IDLE: w_set_press[i] = w_press_edge[i];
            S_HOLD: begin
               w_release[i] = key_in[i];
               w_set_rpt[i] = ~key_in[i] && (r_cnt[i] == HOLD_LAST);
            end
            S_RPT: begin
               w_release[i] = key_in[i];
               w_set_rpt[i] = ~key_in[i] && (r_cnt[i] == RPT_LAST);
            end
            default: ;
         endcase
      end
   end

   // Round-robin search for the first pending key starting at r_rr_ptr
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      for (int k = 0; k < N_KEYS; k++) begin
         if (!w_gnt_found && w_pend_any[f_wrap(r_rr_ptr, KW'(k))]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = f_wrap(r_rr_ptr, KW'(k));
         end
      end
   end

   // Clear only the flag that the grant issues; press goes out before repeat
   always_comb begin
      w_clr_press = '0;
      w_clr_rpt   = '0;
      if (w_grant) begin
         if (r_pend_press[w_gnt_idx]) w_clr_press[w_gnt_idx] = 1'b1;
         else                         w_clr_rpt[w_gnt_idx]   = 1'b1;
      end
   end

   // Key FSMs, hold/repeat counters and pending flags (a new set beats a grant clear)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_key_prev   <= '1;
         r_pend_press <= '0;
         r_pend_rpt   <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            r_state[i] <= S_IDLE;
            r_cnt[i]   <= '0;
         end
      end else begin
         r_key_prev   <= key_in;
         r_pend_press <= (r_pend_press & ~w_clr_press) | w_set_press;
         r_pend_rpt   <= ((r_pend_rpt & ~w_clr_rpt) | w_set_rpt) & ~w_release;
         for (int i = 0; i < N_KEYS; i++) begin
            case (r_state[i])
               S_IDLE: begin
                  if (w_press_edge[i]) begin
                     r_state[i] <= S_HOLD;
                     r_cnt[i]   <= '0;
                  end
               end
               S_HOLD: begin
                  if (key_in[i]) begin
                     r_state[i] <= S_IDLE;
                     r_cnt[i]   <= '0;
                  end else if (r_cnt[i] == HOLD_LAST) begin
                     r_state[i] <= S_RPT;
                     r_cnt[i]   <= '0;
                  end else begin
                     r_cnt[i]   <= r_cnt[i] + 1'b1;
                  end
               end
               S_RPT: begin
                  if (key_in[i]) begin
                     r_state[i] <= S_IDLE;
                     r_cnt[i]   <= '0;
                  end else if (r_cnt[i] == RPT_LAST) begin
                     r_cnt[i]   <= '0;
                  end else begin
                     r_cnt[i]   <= r_cnt[i] + 1'b1;
                  end
               end
               default: begin
                  r_state[i] <= S_IDLE;
                  r_cnt[i]   <= '0;
               end
            endcase
         end
      end
   end

   // Output slot: load on grant, drop valid when freed with nothing pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ev_valid <= 1'b0;
         r_ev_key   <= '0;
         r_ev_type  <= 1'b0;
         r_rr_ptr   <= '0;
      end else if (w_grant) begin
         r_ev_valid <= 1'b1;
         r_ev_key   <= w_gnt_idx;
         r_ev_type  <= ~r_pend_press[w_gnt_idx];
         r_rr_ptr   <= (w_gnt_idx == LAST_KEY) ? '0 : w_gnt_idx + 1'b1;
      end else if (w_slot_free) begin
         r_ev_valid <= 1'b0;
      end
   end

   // Pack FSM states for observation
   always_comb begin
      dbg_state = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         dbg_state[2*i +: 2] = r_state[i];
      end
   end

   assign ev_valid = r_ev_valid;
   assign ev_key   = r_ev_key;
   assign ev_type  = r_ev_type;
   assign key_held = ~r_key_prev;

endmodule
